// File: rtl/wishbone_bus_if.sv
// ---------------------------------------------------------------------------
// wishbone_bus_if
//
// Bridges one OpenMIPS SRAM-style CPU port (data or instruction side) to a
// Wishbone B3 classic master. Each single-cycle CPU access becomes one
// Wishbone cycle. The pipeline is held through stallreq until the slave
// acknowledges. Read data is buffered while some other pipeline stage keeps
// this stage stalled. An access is aborted on a pipeline flush or when the
// slave fails to acknowledge within TIMEOUT_CYCLES.
//
// Parameters
//   STALL_BIT       index of stall_i owned by this port's pipeline stage
//   TIMEOUT_CYCLES  maximum BUSY cycles without ack (1..255)
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   stall_i[5:0]        pipeline stall vector from ctrl
//   flush_i             pipeline flush, aborts any access
//   cpu_ce_i            CPU access request
//   cpu_addr_i[31:0]    byte address
//   cpu_data_i[31:0]    store data
//   cpu_we_i            1 = write
//   cpu_sel_i[3:0]      byte lane enables
//   cpu_data_o[31:0]    load data returned to the CPU (combinational)
//   stallreq            stall request to ctrl (combinational)
//   bus_err_o           one-cycle pulse after a timeout abort
//   wishbone_data_i     slave read data
//   wishbone_ack_i      slave acknowledge
//   wishbone_*_o        registered Wishbone master outputs
// ---------------------------------------------------------------------------
module wishbone_bus_if #(
    parameter int STALL_BIT      = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq,
    output logic        bus_err_o,
    input  logic [31:0] wishbone_data_i,
    input  logic        wishbone_ack_i,
    output logic [31:0] wishbone_addr_o,
    output logic [31:0] wishbone_data_o,
    output logic        wishbone_we_o,
    output logic [3:0]  wishbone_sel_o,
    output logic        wishbone_stb_o,
    output logic        wishbone_cyc_o
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BUSY       = 2'd1,
        WAIT_STALL = 2'd2
    } state_t;

    // Last counter value before the abort; the counter starts at 0 in the
    // first BUSY cycle, so matching this value marks the TIMEOUT_CYCLES-th one.
    localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic        stb_q;
    logic        cyc_q;
    logic [31:0] rd_buf_q;
    logic [7:0]  tcnt_q;
    logic [7:0]  tcnt_d;
    logic        bus_err_q;

    logic        own_stall;
    logic        start_req;
    logic        in_busy;
    logic        ack_take;
    logic        timeout_fire;

    assign own_stall = stall_i[STALL_BIT];
    assign start_req = cpu_ce_i & ~flush_i;
    assign in_busy   = (state_q == BUSY);
    assign tcnt_d    = tcnt_q + 8'd1;

    // Flush outranks ack, and ack outranks the timeout, so the timeout only
    // fires when neither of the other two events is present.
    assign ack_take     = in_busy & ~flush_i & wishbone_ack_i;
    assign timeout_fire = in_busy & ~flush_i & ~wishbone_ack_i & (tcnt_q == TCNT_LAST);

    // Stall request: held from the request cycle until the access resolves,
    // released in the resolving cycle so the pipeline can advance right away.
    always_comb begin
        stallreq = 1'b0;
        case (state_q)
            IDLE:    stallreq = start_req;
            BUSY:    stallreq = ~(wishbone_ack_i | timeout_fire);
            default: stallreq = 1'b0;
        endcase
    end

    // Load data: passed straight through in the ack cycle, replayed from the
    // buffer while the stage is still stalled, otherwise zero.
    always_comb begin
        cpu_data_o = 32'h0;
        if (in_busy && wishbone_ack_i) begin
            cpu_data_o = wishbone_data_i;
        end else if (state_q == WAIT_STALL) begin
            cpu_data_o = rd_buf_q;
        end
    end

    // Main FSM with all registered outputs. Address, data, we and sel are
    // only loaded when a cycle starts, which keeps them stable while stb is
    // high. bus_err defaults low each cycle so it forms a single pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            we_q      <= 1'b0;
            sel_q     <= 4'h0;
            stb_q     <= 1'b0;
            cyc_q     <= 1'b0;
            rd_buf_q  <= 32'h0;
            tcnt_q    <= 8'h0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_req) begin
                        addr_q  <= cpu_addr_i;
                        wdata_q <= cpu_data_i;
                        we_q    <= cpu_we_i;
                        sel_q   <= cpu_sel_i;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        tcnt_q  <= 8'h0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush_i) begin
                        cyc_q    <= 1'b0;
                        stb_q    <= 1'b0;
                        rd_buf_q <= 32'h0;
                        state_q  <= IDLE;
                    end else if (ack_take) begin
                        cyc_q    <= 1'b0;
                        stb_q    <= 1'b0;
                        rd_buf_q <= wishbone_data_i;
                        state_q  <= own_stall ? WAIT_STALL : IDLE;
                    end else if (timeout_fire) begin
                        cyc_q     <= 1'b0;
                        stb_q     <= 1'b0;
                        rd_buf_q  <= 32'h0;
                        bus_err_q <= 1'b1;
                        state_q   <= own_stall ? WAIT_STALL : IDLE;
                    end else begin
                        tcnt_q <= tcnt_d;
                    end
                end
                WAIT_STALL: begin
                    if (flush_i) begin
                        rd_buf_q <= 32'h0;
                        state_q  <= IDLE;
                    end else if (!own_stall) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wishbone_addr_o = addr_q;
    assign wishbone_data_o = wdata_q;
    assign wishbone_we_o   = we_q;
    assign wishbone_sel_o  = sel_q;
    assign wishbone_stb_o  = stb_q;
    assign wishbone_cyc_o  = cyc_q;
    assign bus_err_o       = bus_err_q;

endmodule

// File: tb/tb_wishbone_bus_if.sv
// ---------------------------------------------------------------------------
// tb_wishbone_bus_if
//
// Drives wishbone_bus_if one access at a time. Each access is described by
// its request fields, the slave wait count, the number of cycles the owning
// stage stays stalled afterwards and an optional flush point. The expected
// per-cycle behaviour is derived from that description. Inputs change 1 ns
// after the rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_wishbone_bus_if;

    localparam int SB = 3;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        cpu_ce_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic        cpu_we_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_o;
    logic        stallreq;
    logic        bus_err_o;
    logic [31:0] wb_di;
    logic        wb_ack;
    logic [31:0] wb_addr;
    logic [31:0] wb_do;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic        wb_stb;
    logic        wb_cyc;

    int nCompared   = 0;
    int nMismatched = 0;
    bit expErr      = 1'b0;

    always #5 clk = ~clk;

    wishbone_bus_if #(
        .STALL_BIT      (SB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .cpu_ce_i        (cpu_ce_i),
        .cpu_addr_i      (cpu_addr_i),
        .cpu_data_i      (cpu_data_i),
        .cpu_we_i        (cpu_we_i),
        .cpu_sel_i       (cpu_sel_i),
        .cpu_data_o      (cpu_data_o),
        .stallreq        (stallreq),
        .bus_err_o       (bus_err_o),
        .wishbone_data_i (wb_di),
        .wishbone_ack_i  (wb_ack),
        .wishbone_addr_o (wb_addr),
        .wishbone_data_o (wb_do),
        .wishbone_we_o   (wb_we),
        .wishbone_sel_o  (wb_sel),
        .wishbone_stb_o  (wb_stb),
        .wishbone_cyc_o  (wb_cyc)
    );

    // Random stall vector with this port's bit forced to the given value.
    function automatic logic [5:0] mk_stall(input bit own);
        logic [5:0] v;
        v     = 6'($urandom);
        v[SB] = own;
        return v;
    endfunction

    // One cycle with no request: the bridge must stay idle and silent.
    task automatic idle_cycle(input string name, input bit strayAck);
        @(posedge clk); #1;
        cpu_ce_i   = 1'b0;
        flush_i    = 1'b0;
        wb_ack     = strayAck;
        wb_di      = $urandom;
        stall_i    = mk_stall(1'b0);
        cpu_addr_i = $urandom;
        cpu_data_i = $urandom;
        cpu_we_i   = 1'($urandom);
        cpu_sel_i  = 4'($urandom);
        @(negedge clk);
        nCompared++; if (wb_cyc !== 1'b0) begin nMismatched++; $display("[TB] FAIL %s idle_cyc: got %b want 0", name, wb_cyc); end
        nCompared++; if (wb_stb !== 1'b0) begin nMismatched++; $display("[TB] FAIL %s idle_stb: got %b want 0", name, wb_stb); end
        nCompared++; if (stallreq !== 1'b0) begin nMismatched++; $display("[TB] FAIL %s idle_stallreq: got %b want 0", name, stallreq); end
        nCompared++; if (cpu_data_o !== 32'h0) begin nMismatched++; $display("[TB] FAIL %s idle_data: got %h want 0", name, cpu_data_o); end
        nCompared++; if (bus_err_o !== expErr) begin nMismatched++; $display("[TB] FAIL %s idle_err: got %b want %b", name, bus_err_o, expErr); end
        expErr = 1'b0;
    endtask

    // One complete access. waitN = wait states before ack (waitN+1 > TO means
    // the slave never answers), holdN = cycles spent stalled after completion
    // (the last of them releases the stall, or flushes when exitFlush is set),
    // flushAt = BUSY cycle that carries a flush (0 = none).
    task automatic do_access(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic we, input logic [3:0] sel, input int waitN, input int holdN,
                             input logic [31:0] rdata, input int flushAt, input bit exitFlush);
        logic [31:0] bufExp;
        logic [31:0] dataExp;
        bit ackIn, flushIn, toNow, done, timedOut, wentWait, srExp;
        done     = 1'b0;
        timedOut = 1'b0;
        wentWait = 1'b0;
        bufExp   = 32'h0;

        // Request cycle, still IDLE.
        @(posedge clk); #1;
        cpu_ce_i   = 1'b1;
        flush_i    = 1'b0;
        cpu_addr_i = addr;
        cpu_data_i = wdata;
        cpu_we_i   = we;
        cpu_sel_i  = sel;
        wb_ack     = 1'($urandom);
        wb_di      = $urandom;
        stall_i    = mk_stall(1'($urandom));
        @(negedge clk);
        nCompared++; if (wb_cyc !== 1'b0) begin nMismatched++; $display("[TB] FAIL %s req_cyc: got %b want 0", name, wb_cyc); end
        nCompared++; if (stallreq !== 1'b1) begin nMismatched++; $display("[TB] FAIL %s req_stallreq: got %b want 1", name, stallreq); end
        nCompared++; if (cpu_data_o !== 32'h0) begin nMismatched++; $display("[TB] FAIL %s req_data: got %h want 0", name, cpu_data_o); end
        nCompared++; if (bus_err_o !== expErr) begin nMismatched++; $display("[TB] FAIL %s req_err: got %b want %b", name, bus_err_o, expErr); end
        expErr = 1'b0;

        // BUSY cycles; CPU-side inputs are scrambled to prove they were latched.
        for (int b = 1; !done; b++) begin
            @(posedge clk); #1;
            ackIn   = (b == waitN + 1) && (waitN + 1 <= TO);
            flushIn = (b == flushAt);
            toNow   = !ackIn && !flushIn && (b == TO);
            cpu_ce_i   = 1'($urandom);
            cpu_addr_i = $urandom;
            cpu_data_i = $urandom;
            cpu_we_i   = 1'($urandom);
            cpu_sel_i  = 4'($urandom);
            wb_ack     = ackIn;
            wb_di      = ackIn ? rdata : $urandom;
            flush_i    = flushIn;
            stall_i    = mk_stall(((ackIn || toNow) && !flushIn) ? (holdN > 0) : 1'($urandom));
            srExp      = !(ackIn || toNow);
            dataExp    = ackIn ? rdata : 32'h0;
            @(negedge clk);
            nCompared++; if (wb_cyc !== 1'b1) begin nMismatched++; $display("[TB] FAIL %s busy%0d_cyc: got %b want 1", name, b, wb_cyc); end
            nCompared++; if (wb_stb !== 1'b1) begin nMismatched++; $display("[TB] FAIL %s busy%0d_stb: got %b want 1", name, b, wb_stb); end
            nCompared++; if (wb_addr !== addr) begin nMismatched++; $display("[TB] FAIL %s busy%0d_addr: got %h want %h", name, b, wb_addr, addr); end
            nCompared++; if (wb_do !== wdata) begin nMismatched++; $display("[TB] FAIL %s busy%0d_wdata: got %h want %h", name, b, wb_do, wdata); end
            nCompared++; if (wb_we !== we) begin nMismatched++; $display("[TB] FAIL %s busy%0d_we: got %b want %b", name, b, wb_we, we); end
            nCompared++; if (wb_sel !== sel) begin nMismatched++; $display("[TB] FAIL %s busy%0d_sel: got %h want %h", name, b, wb_sel, sel); end
            nCompared++; if (stallreq !== srExp) begin nMismatched++; $display("[TB] FAIL %s busy%0d_stallreq: got %b want %b", name, b, stallreq, srExp); end
            nCompared++; if (bus_err_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL %s busy%0d_err: got %b want 0", name, b, bus_err_o); end
            if (!flushIn) begin
                nCompared++; if (cpu_data_o !== dataExp) begin nMismatched++; $display("[TB] FAIL %s busy%0d_data: got %h want %h", name, b, cpu_data_o, dataExp); end
            end
            if (!flushIn && ackIn) bufExp = rdata;
            if (toNow) timedOut = 1'b1;
            wentWait = (ackIn || toNow) && !flushIn && (holdN > 0);
            done     = ackIn || flushIn || toNow;
        end

        // Completed but the owning stage is still stalled: buffered data replayed.
        if (wentWait) begin
            for (int w = 1; w <= holdN; w++) begin
                @(posedge clk); #1;
                cpu_ce_i = 1'($urandom);
                wb_ack   = 1'($urandom);
                wb_di    = $urandom;
                flush_i  = (w == holdN) && exitFlush;
                stall_i  = mk_stall((w < holdN) || exitFlush);
                @(negedge clk);
                nCompared++; if (wb_cyc !== 1'b0) begin nMismatched++; $display("[TB] FAIL %s wait%0d_cyc: got %b want 0", name, w, wb_cyc); end
                nCompared++; if (stallreq !== 1'b0) begin nMismatched++; $display("[TB] FAIL %s wait%0d_stallreq: got %b want 0", name, w, stallreq); end
                nCompared++; if (cpu_data_o !== bufExp) begin nMismatched++; $display("[TB] FAIL %s wait%0d_data: got %h want %h", name, w, cpu_data_o, bufExp); end
                nCompared++; if (bus_err_o !== (timedOut && w == 1)) begin nMismatched++; $display("[TB] FAIL %s wait%0d_err: got %b want %b", name, w, bus_err_o, (timedOut && w == 1)); end
            end
            expErr = 1'b0;
        end else begin
            expErr = timedOut;
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        stall_i    = 6'h0;
        flush_i    = 1'b0;
        cpu_ce_i   = 1'b0;
        cpu_addr_i = 32'h0;
        cpu_data_i = 32'h0;
        cpu_we_i   = 1'b0;
        cpu_sel_i  = 4'h0;
        wb_di      = 32'h0;
        wb_ack     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nCompared++; if (wb_cyc !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_cyc: got %b want 0", wb_cyc); end
        nCompared++; if (wb_stb !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_stb: got %b want 0", wb_stb); end
        nCompared++; if (wb_we !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_we: got %b want 0", wb_we); end
        nCompared++; if (wb_addr !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_addr: got %h want 0", wb_addr); end
        nCompared++; if (wb_do !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_wdata: got %h want 0", wb_do); end
        nCompared++; if (wb_sel !== 4'h0) begin nMismatched++; $display("[TB] FAIL reset_sel: got %h want 0", wb_sel); end
        nCompared++; if (bus_err_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_err: got %b want 0", bus_err_o); end
        nCompared++; if (stallreq !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_stallreq: got %b want 0", stallreq); end
        nCompared++; if (cpu_data_o !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_data: got %h want 0", cpu_data_o); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_zero_wait_read();
        do_access("zero_wait", 32'h0000_0100, 32'h0, 1'b0, 4'hF, 0, 0, 32'hDEAD_BEEF, 0, 1'b0);
        idle_cycle("zero_wait_after", 1'b0);
    endtask

    task automatic test_byte_write_wait();
        do_access("byte_write", 32'h0000_0203, 32'h0000_00AB, 1'b1, 4'b0001, 3, 0, 32'h5555_AAAA, 0, 1'b0);
        idle_cycle("byte_write_after", 1'b0);
    endtask

    task automatic test_read_stall();
        do_access("read_stall", 32'h0000_0400, 32'h0, 1'b0, 4'hF, 1, 5, 32'h1234_5678, 0, 1'b0);
        idle_cycle("read_stall_after", 1'b0);
    endtask

    task automatic test_flush_abort();
        do_access("flush_abort", 32'h0000_0500, 32'h0, 1'b0, 4'hF, 1, 0, 32'hCAFE_F00D, 2, 1'b0);
        idle_cycle("flush_abort_after", 1'b0);
    endtask

    task automatic test_timeout();
        do_access("timeout", 32'h0000_0600, 32'h0, 1'b0, 4'hF, TO + 3, 0, 32'h0, 0, 1'b0);
        idle_cycle("timeout_pulse", 1'b0);
        idle_cycle("timeout_after", 1'b0);
    endtask

    task automatic test_idle_flush();
        @(posedge clk); #1;
        cpu_ce_i = 1'b1;
        flush_i  = 1'b1;
        wb_ack   = 1'b0;
        @(negedge clk);
        nCompared++; if (stallreq !== 1'b0) begin nMismatched++; $display("[TB] FAIL idle_flush_stallreq: got %b want 0", stallreq); end
        idle_cycle("idle_flush_after", 1'b0);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        cpu_ce_i   = 1'b1;
        flush_i    = 1'b0;
        cpu_addr_i = 32'h0000_0700;
        cpu_we_i   = 1'b0;
        cpu_sel_i  = 4'hF;
        wb_ack     = 1'b0;
        stall_i    = mk_stall(1'b0);
        @(posedge clk); #1;
        cpu_ce_i = 1'b0;
        @(negedge clk);
        nCompared++; if (wb_cyc !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_mid_busy_cyc: got %b want 1", wb_cyc); end
        #2 rst = 1'b1;
        #1;
        nCompared++; if (wb_cyc !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_mid_cyc: got %b want 0", wb_cyc); end
        nCompared++; if (wb_stb !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_mid_stb: got %b want 0", wb_stb); end
        nCompared++; if (stallreq !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_mid_stallreq: got %b want 0", stallreq); end
        @(posedge clk); #1;
        wb_ack = 1'b1;
        wb_di  = 32'h7777_7777;
        #2 rst = 1'b0;
        expErr = 1'b0;
        idle_cycle("reset_mid_stray_ack", 1'b1);
        idle_cycle("reset_mid_after", 1'b0);
    endtask

    task automatic test_back_to_back();
        do_access("b2b_first", 32'h0000_0800, 32'h1111_2222, 1'b1, 4'b1100, 0, 0, 32'h0, 0, 1'b0);
        do_access("b2b_second", 32'h0000_0804, 32'h0, 1'b0, 4'hF, 1, 0, 32'h3333_4444, 0, 1'b0);
        idle_cycle("b2b_after", 1'b0);
    endtask

    task automatic test_random();
        int waitN, holdN, flushAt;
        for (int i = 0; i < 40; i++) begin
            waitN   = int'($urandom_range(0, TO + 1));
            holdN   = int'($urandom_range(0, 3));
            flushAt = ($urandom_range(0, 4) == 0) ?
                      int'($urandom_range(1, (waitN + 1 < TO) ? waitN + 1 : TO)) : 0;
            do_access("random", $urandom, $urandom, 1'($urandom), 4'($urandom),
                      waitN, holdN, $urandom, flushAt, 1'($urandom));
            if ($urandom_range(0, 1) == 1) idle_cycle("random_gap", 1'($urandom));
        end
        idle_cycle("random_after", 1'b0);
    endtask

    initial begin
        test_reset();
        test_zero_wait_read();
        test_byte_write_wait();
        test_read_stall();
        test_flush_abort();
        test_timeout();
        test_idle_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
